// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the fetch-queue entry that carries a
// fetched instruction together with its PC+4.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t npc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular FIFO with occupancy count; flush empties it in one cycle.
// Entry storage is never cleared, only the pointers and count.
module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int   DEPTH   = 4,
  parameter type  entry_t = fetch_entry_t,
  localparam int  CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           wdata,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = bump(wr_q);
      if (pop_ok)  rd_d = bump(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST && !flush && push_ok) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator feeding a prefetch FIFO of
// {npc, instr}; redirect flushes and refetches, fetch_halt stops new requests.
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    DEPTH   = 4,
  localparam int   CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  output logic [31:0]      imemaddr,
  output logic             imemREN,
  input  logic             deq,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             fetch_halt,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_npc,
  output logic [CNT_W-1:0] count
);

  word_t        pc_q, pc_d;
  logic         full, empty, push, pop;
  fetch_entry_t wdata, head;

  // Request depends only on registered fullness, so a pop frees a slot for
  // the following cycle rather than combinationally.
  assign imemREN  = !full && !fetch_halt && !redirect;
  assign imemaddr = pc_q;
  assign push     = imemREN && ihit;
  assign pop      = deq && !empty && !redirect;
  assign wdata    = '{npc: pc_q + PC_STEP, instr: imemload};

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = {redirect_pc[31:2], 2'b00};
    else if (push) pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge CLK) begin
    if (nRST) pc_q <= PC_INIT;
    else      pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_npc   = out_valid ? head.npc   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Drives DEPTH=4 and DEPTH=3 fetch queues with identical stimulus and checks
// both against a queue-based reference model every cycle.
module tb_fetch_queue;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST, ihit, deq, redirect, fetch_halt;
  logic [31:0] imemload, redirect_pc;

  logic [31:0] addr_o [2];
  logic [31:0] instr_o[2];
  logic [31:0] npc_o  [2];
  logic [31:0] cnt_o  [2];
  logic        ren_o  [2];
  logic        vld_o  [2];
  logic [2:0]  cnt4;
  logic [1:0]  cnt3;

  always #5 CLK = ~CLK;

  fetch_queue #(.PC_INIT(PC_INIT), .DEPTH(4)) u_d4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemaddr(addr_o[0]), .imemREN(ren_o[0]), .deq(deq), .redirect(redirect),
    .redirect_pc(redirect_pc), .fetch_halt(fetch_halt), .out_valid(vld_o[0]),
    .out_instr(instr_o[0]), .out_npc(npc_o[0]), .count(cnt4)
  );

  fetch_queue #(.PC_INIT(PC_INIT), .DEPTH(3)) u_d3 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemaddr(addr_o[1]), .imemREN(ren_o[1]), .deq(deq), .redirect(redirect),
    .redirect_pc(redirect_pc), .fetch_halt(fetch_halt), .out_valid(vld_o[1]),
    .out_instr(instr_o[1]), .out_npc(npc_o[1]), .count(cnt3)
  );

  assign cnt_o[0] = 32'(cnt4);
  assign cnt_o[1] = 32'(cnt3);

  // Reference model: one queue of {npc, instr} plus a PC per DUT.
  logic [63:0] mq [2][$];
  logic [31:0] mpc[2];
  int          mdepth[2] = '{4, 3};

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    if (nRST) return;
    for (int d = 0; d < 2; d++) begin
      int          sz;
      logic [63:0] h;
      sz = mq[d].size();
      h  = (sz != 0) ? mq[d][0] : 64'h0;
      chk($sformatf("d%0d_count", d), cnt_o[d], 32'(sz));
      chk($sformatf("d%0d_valid", d), 32'(vld_o[d]), 32'(sz != 0));
      chk($sformatf("d%0d_addr", d), addr_o[d], mpc[d]);
      chk($sformatf("d%0d_ren", d), 32'(ren_o[d]),
          32'(sz != mdepth[d] && !fetch_halt && !redirect));
      chk($sformatf("d%0d_npc", d), npc_o[d], h[63:32]);
      chk($sformatf("d%0d_instr", d), instr_o[d], h[31:0]);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (nRST) begin
        mpc[d] = PC_INIT;
        mq[d].delete();
      end else if (redirect) begin
        mpc[d] = redirect_pc & 32'hFFFF_FFFC;
        mq[d].delete();
      end else begin
        bit do_push, do_pop;
        do_push = (mq[d].size() != mdepth[d]) && !fetch_halt && ihit;
        do_pop  = deq && (mq[d].size() != 0);
        if (do_pop) void'(mq[d].pop_front());
        if (do_push) begin
          mq[d].push_back({mpc[d] + 32'd4, imemload});
          mpc[d] = mpc[d] + 32'd4;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_model();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic r, input logic h, input logic [31:0] w,
                        input logic q, input logic rd, input logic [31:0] rpc,
                        input logic hl);
    nRST = r; ihit = h; imemload = w; deq = q;
    redirect = rd; redirect_pc = rpc; fetch_halt = hl;
  endtask

  initial begin
    mpc[0] = 32'hx; mpc[1] = 32'hx;
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle();

    // Reset values
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_addr", addr_o[0], PC_INIT);
    chk("rst_count", cnt_o[0], 32'd0);
    chk("rst_valid", 32'(vld_o[0]), 32'd0);
    chk("rst_npc", npc_o[0], 32'd0);

    // Fill with a constant word
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 32'h2001_0005, 0, 0, 0, 0);
      cycle();
    end
    #1;
    chk("full_count", cnt_o[0], 32'd4);
    chk("full_ren", 32'(ren_o[0]), 32'd0);
    chk("full_addr", addr_o[0], 32'h10);
    chk("full_npc", npc_o[0], 32'h4);
    chk("full3_count", cnt_o[1], 32'd3);

    // One pop while full frees a slot next cycle
    set_in(0, 1, 32'hAAAA_0001, 1, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pop_count", cnt_o[0], 32'd3);
    chk("pop_ren", 32'(ren_o[0]), 32'd1);
    chk("pop_npc", npc_o[0], 32'h8);
    cycle();

    // Simultaneous push and pop
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 32'hB000_0000 + 32'(i), 1, 0, 0, 0);
      cycle();
    end

    // Redirect discards same-cycle ihit and deq
    set_in(0, 1, 32'hDEAD_BEEF, 1, 1, 32'h0000_0103, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("redir_count", cnt_o[0], 32'd0);
    chk("redir_valid", 32'(vld_o[0]), 32'd0);
    chk("redir_addr", addr_o[0], 32'h100);
    cycle();

    // Two entries, then drain under fetch_halt, then release
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 32'hC000_0000 + 32'(i), 0, 0, 0, 0);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 32'hEEEE_0000, 1, 0, 0, 1);
      cycle();
    end
    #1;
    chk("halt_count", cnt_o[0], 32'd0);
    chk("halt_addr", addr_o[0], 32'h108);
    set_in(0, 1, 32'hC000_0002, 0, 0, 0, 0);
    cycle();
    chk("resume_npc", npc_o[0], 32'h10C);

    // PC wrap at the top of the address space
    set_in(0, 0, 0, 0, 1, 32'hFFFF_FFF6, 0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, $urandom, i[0], 0, 0, 0);
      cycle();
    end

    // Random traffic, with biased phases to hit full and empty often
    for (int i = 0; i < 800; i++) begin
      int ph;
      ph = (i / 100) % 3;
      set_in($urandom_range(0, 149) == 0,
             $urandom_range(0, 3) != 0 && (ph != 2 || $urandom_range(0, 1) == 0),
             $urandom,
             (ph == 0) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 2) != 0,
             $urandom_range(0, 24) == 0,
             ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom,
             $urandom_range(0, 9) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
